// File: rtl/if_id_pipe.sv
// if_id_pipe: IF/ID pipeline register with valid/ready handshake, optional skid buffer, flush and stall counter
module if_id_pipe #(
  parameter int INS_W = 32,
  parameter int PC_W = 32,
  parameter logic [INS_W-1:0] NOP_INS = '0,
  parameter bit SKID = 1'b1,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INS_W-1:0]   ins_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               flush,
  output logic [INS_W-1:0]   ins_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [STALL_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;
  state_t r_state, w_next;
  logic r_ready;
  logic [INS_W-1:0] r_m_ins, r_s_ins;
  logic [PC_W-1:0] r_m_pc, r_s_pc;
  logic [STALL_W-1:0] r_stall;
  logic w_accept, w_retire, w_ld_in, w_ld_s, w_ld_sm;
  assign valid_o = r_state != ST_EMPTY;
  assign ready_o = SKID ? r_ready : (~valid_o | ready_i);
  assign ins_o = valid_o ? r_m_ins : NOP_INS;
  assign pc_o = r_m_pc;
  assign stall_cnt = r_stall;
  assign w_accept = valid_i & ready_o;
  assign w_retire = valid_o & ready_i;
  // next state and register load enables; flush overrides every load
  always_comb begin
    w_next = flush ? ST_EMPTY :
             r_state == ST_EMPTY ? (w_accept ? ST_FULL : ST_EMPTY) :
             r_state == ST_FULL ? (w_accept ? (w_retire ? ST_FULL : ST_SKID) : (w_retire ? ST_EMPTY : ST_FULL)) :
             (w_retire ? ST_FULL : ST_SKID);
    w_ld_in = ~flush & w_accept & (r_state == ST_EMPTY | w_retire);
    w_ld_s = ~flush & w_accept & r_state == ST_FULL & ~w_retire;
    w_ld_sm = ~flush & r_state == ST_SKID & w_retire;
  end
  // control state, registered ready, shown PC and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_ready <= 1'b1;
      r_m_pc <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= w_next != ST_SKID;
      r_m_pc <= w_ld_in ? pc_i : w_ld_sm ? r_s_pc : r_m_pc;
      r_stall <= (valid_o & ~ready_i & ~&r_stall) ? r_stall + 1'b1 : r_stall;
    end
  end
  // data payload registers; only loaded on real transfers so idle-bus X never reaches ins_o
  always_ff @(posedge clk) begin
    r_m_ins <= w_ld_in ? ins_i : w_ld_sm ? r_s_ins : r_m_ins;
    r_s_ins <= w_ld_s ? ins_i : r_s_ins;
    r_s_pc <= w_ld_s ? pc_i : r_s_pc;
  end
endmodule

// File: tb/tb_if_id_pipe.sv
// tb_if_id_pipe: randomized and directed check of if_id_pipe (skid and no-skid) against a beat-queue model
module tb_if_id_pipe;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] ins_i = '0, pc_i = '0;
  logic valid_i = 1'b0, ready_i = 1'b0, flush = 1'b0;
  logic r1, v1, r0, v0;
  logic [31:0] i1, p1, i0, p0;
  logic [3:0] s1;
  logic [15:0] s0;
  int checks = 0, errors = 0;
  logic [31:0] e_ins[2][2], e_pc[2][2], lpc[2];
  int n[2], st[2];
  bit cur_rdy = 1'b0;

  always #5 clk = ~clk;

  if_id_pipe #(.NOP_INS(NOP), .SKID(1'b1), .STALL_W(4)) dut1 (
    .clk(clk), .rst(rst), .ins_i(ins_i), .pc_i(pc_i), .valid_i(valid_i), .ready_o(r1),
    .flush(flush), .ins_o(i1), .pc_o(p1), .valid_o(v1), .ready_i(ready_i), .stall_cnt(s1));
  if_id_pipe #(.NOP_INS(NOP), .SKID(1'b0), .STALL_W(16)) dut0 (
    .clk(clk), .rst(rst), .ins_i(ins_i), .pc_i(pc_i), .valid_i(valid_i), .ready_o(r0),
    .flush(flush), .ins_o(i0), .pc_o(p0), .valid_o(v0), .ready_i(ready_i), .stall_cnt(s0));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // stage accepts while it holds fewer than two beats (skid) or is empty / being drained (no skid)
  function automatic bit exp_rdy(input int k);
    return k == 1 ? n[1] < 2 : (n[0] == 0 || cur_rdy);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("valid%0d", k), k ? v1 : v0, n[k] > 0);
      chk($sformatf("ready%0d", k), k ? r1 : r0, exp_rdy(k));
      chk($sformatf("ins%0d", k), k ? i1 : i0, n[k] > 0 ? e_ins[k][0] : NOP);
      chk($sformatf("pc%0d", k), k ? p1 : p0, n[k] > 0 ? e_pc[k][0] : lpc[k]);
      chk($sformatf("stall%0d", k), k ? {12'd0, s1} : s0, st[k]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0;
      st[k] = 0;
      lpc[k] = '0;
    end
  endtask

  // check current outputs, then drive one beat worth of inputs and advance the model over the next edge
  task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc, input bit r, input bit f);
    @(negedge clk);
    check_all();
    valid_i = v;
    ins_i = v ? ins : 'x;
    pc_i = v ? pc : 'x;
    ready_i = r;
    flush = f;
    cur_rdy = r;
    for (int k = 0; k < 2; k++) begin
      bit acc, ret;
      acc = v & exp_rdy(k);
      ret = n[k] > 0 && r;
      if (n[k] > 0 && !r && st[k] < (k ? 15 : 65535)) st[k]++;
      if (ret) begin
        e_ins[k][0] = e_ins[k][1];
        e_pc[k][0] = e_pc[k][1];
        n[k]--;
      end
      if (acc) begin
        e_ins[k][n[k]] = ins;
        e_pc[k][n[k]] = pc;
        n[k]++;
      end
      if (f) n[k] = 0;
      if (n[k] > 0) lpc[k] = e_pc[k][0];
    end
  endtask

  // asynchronous reset asserted between edges, outputs checked before any clock edge
  task automatic do_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    valid_i = 1'b0;
    flush = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_ins1", i1, NOP);
    chk("rst_rdy1", r1, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1, 32'h1000 + i, i * 4, 1, 0);
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h2040, 32'h40, 0, 0);
    cyc(1, 32'h2044, 32'h44, 0, 0);
    repeat (3) cyc(1, 32'h2048, 32'h48, 0, 0);
    repeat (2) cyc(1, 32'h2048, 32'h48, 1, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h2040, 32'h40, 0, 0);
    cyc(1, 32'h2044, 32'h44, 0, 0);
    cyc(1, 32'h2048, 32'h48, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h2080, 32'h80, 1, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    do_rst();
    cyc(1, 32'h3000, 32'h200, 0, 0);
    repeat (20) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (2) cyc(0, 0, 0, 0, 0);
    do_rst();
    for (int i = 0; i < 8; i++) cyc(1, 32'h4000 + i, 32'h300 + i * 4, i % 2 == 0, 0);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h5000, 32'h500, 0, 0);
    repeat (2) cyc(1, 32'h5004, 32'h504, 0, 0);
    do_rst();
    for (int i = 0; i < 500; i++) begin
      cyc($urandom % 4 != 0, $urandom, $urandom, $urandom % 3 != 0, $urandom % 16 == 0);
      if (i == 250) do_rst();
    end
    repeat (3) cyc(0, 0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
